// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
//   Shared timing constants for the VGA raster path. The defaults describe
//   640x480@60 Hz from a 100 MHz system clock (4 system clocks per pixel).
//   The totals and sync-window bounds are derived here so that every consumer
//   agrees on them. in_window() is the half-open range test used for the
//   video_on, hsync and vsync decodes.
// ---------------------------------------------------------------------------
package vga_pkg;

  localparam int DEF_CLK_DIV   = 4;

  localparam int DEF_H_DISPLAY = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;

  localparam int DEF_V_DISPLAY = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  localparam int DEF_H_TOTAL   = DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int DEF_V_TOTAL   = DEF_V_DISPLAY + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  localparam int DEF_HS_START  = DEF_H_DISPLAY + DEF_H_FRONT;
  localparam int DEF_HS_END    = DEF_HS_START + DEF_H_SYNC;
  localparam int DEF_VS_START  = DEF_V_DISPLAY + DEF_V_FRONT;
  localparam int DEF_VS_END    = DEF_VS_START + DEF_V_SYNC;

  // 0 = active-low sync pulses
  localparam bit DEF_SYNC_POL  = 1'b0;

  // True when lo <= value < hi
  function automatic logic in_window(input logic [9:0] value, input int lo, input int hi);
    return (int'(value) >= lo) && (int'(value) < hi);
  endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// ---------------------------------------------------------------------------
// pixel_tick_gen
//   Divides the system clock into a one-clock pixel tick every CLK_DIV clocks.
//   The divider counts 0..CLK_DIV-1. p_tick is registered, so it is high in
//   exactly the clock in which the count equals CLK_DIV-1. It is low during
//   reset. With CLK_DIV = 1 no counter exists, and p_tick stays high from the
//   first edge after reset release.
// Ports
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   p_tick   out  pixel-rate enable pulse
// ---------------------------------------------------------------------------
module pixel_tick_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic reset_n,
  output logic p_tick
);

  if (CLK_DIV <= 1) begin : g_pass
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) p_tick <= 1'b0;
      else          p_tick <= 1'b1;
    end
  end else begin : g_div
    localparam int            DW   = $clog2(CLK_DIV);
    localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div;
    logic [DW-1:0] div_next;

    always_comb begin
      div_next = (div == LAST) ? '0 : div + DW'(1);
    end

    // The tick is loaded from the next divider value.
    // This keeps it aligned with div == LAST without a combinational output.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        div    <= '0;
        p_tick <= 1'b0;
      end else begin
        div    <= div_next;
        p_tick <= (div_next == LAST);
      end
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// ---------------------------------------------------------------------------
// vga_sync_gen
//   Raster timing generator. It runs the horizontal and vertical counters on
//   the pixel tick. It produces registered video_on, hsync and vsync that are
//   aligned with x and y.
// Ports
//   clk         in   system clock
//   reset_n     in   asynchronous active-low reset
//   p_tick      out  pixel tick (one clk every CLK_DIV clks)
//   x, y        out  current raster position (10 bits each)
//   video_on    out  1 inside the visible area
//   hsync       out  horizontal sync, asserted level = SYNC_POL
//   vsync       out  vertical sync, asserted level = SYNC_POL
//   frame_tick  out  one-clk pulse when (x,y) becomes (0,V_DISPLAY+1)
// Configuration
//   VGA_FRAME_TICK_EN: when defined, frame_tick is generated. Otherwise it is
//   tied low and the port is kept.
// ---------------------------------------------------------------------------
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter int H_DISPLAY = DEF_H_DISPLAY,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_DISPLAY = DEF_V_DISPLAY,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  parameter bit SYNC_POL  = DEF_SYNC_POL
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic       p_tick,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_tick
);

  localparam int H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_DISPLAY + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_DISPLAY + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  logic [9:0] x_next;
  logic [9:0] y_next;
  logic       video_next;
  logic       hsync_next;
  logic       vsync_next;

  pixel_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .p_tick  (p_tick)
  );

  // The next raster position. The counters move only on the pixel tick, and
  // the explicit wrap keeps x and y inside 0..TOTAL-1.
  always_comb begin
    x_next = x;
    y_next = y;
    if (p_tick) begin
      if (x == H_LAST) begin
        x_next = '0;
        y_next = (y == V_LAST) ? '0 : y + 10'd1;
      end else begin
        x_next = x + 10'd1;
      end
    end
  end

  // The decode runs on the next position and is registered. The outputs
  // therefore change on the same edge as x and y, and they do not glitch.
  always_comb begin
    video_next = in_window(x_next, 0, H_DISPLAY) && in_window(y_next, 0, V_DISPLAY);
    hsync_next = in_window(x_next, HS_START, HS_END) ? SYNC_POL : ~SYNC_POL;
    vsync_next = in_window(y_next, VS_START, VS_END) ? SYNC_POL : ~SYNC_POL;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x        <= '0;
      y        <= '0;
      video_on <= 1'b0;
      hsync    <= ~SYNC_POL;
      vsync    <= ~SYNC_POL;
    end else begin
      x        <= x_next;
      y        <= y_next;
      video_on <= video_next;
      hsync    <= hsync_next;
      vsync    <= vsync_next;
    end
  end

`ifdef VGA_FRAME_TICK_EN
  localparam logic [9:0] FT_Y = 10'(V_DISPLAY + 1);

  // The pulse is qualified by p_tick. Without it, the position (0,FT_Y)
  // would be seen for CLK_DIV clocks and the pulse would repeat.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) frame_tick <= 1'b0;
    else          frame_tick <= p_tick && (x_next == '0) && (y_next == FT_Y);
  end
`else
  assign frame_tick = 1'b0;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_sync_gen
//   Bench for vga_sync_gen. It uses two instances with a reduced raster so
//   that whole frames fit in a short run:
//     dut0: CLK_DIV=3, active-low sync
//     dut1: CLK_DIV=1, active-high sync
//   The expected outputs come from the number of clock edges since reset
//   release. That count gives the number of pixel ticks, and the position is
//   that count modulo the frame size.
// ---------------------------------------------------------------------------
module tb_vga_sync_gen;

  localparam int HD = 8, HF = 2, HS = 3, HB = 2;
  localparam int VD = 6, VF = 1, VS = 2, VB = 2;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;
  localparam int D0 = 3;
  localparam int D1 = 1;
  localparam bit POL0 = 1'b0;
  localparam bit POL1 = 1'b1;

  logic clk = 1'b0;
  logic rst0_n = 1'b0;
  logic rst1_n = 1'b0;

  logic       p_tick0, video_on0, hsync0, vsync0, frame_tick0;
  logic [9:0] x0, y0;
  logic       p_tick1, video_on1, hsync1, vsync1, frame_tick1;
  logic [9:0] x1, y1;

  logic [24:0] obs0, obs1;
  assign obs0 = {p_tick0, x0, y0, video_on0, hsync0, vsync0, frame_tick0};
  assign obs1 = {p_tick1, x1, y1, video_on1, hsync1, vsync1, frame_tick1};

  int tests = 0;
  int fails = 0;
  int n0 = 0;
  int n1 = 0;

  always #5 clk = ~clk;

  vga_sync_gen #(
    .CLK_DIV(D0), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_POL(POL0)
  ) dut0 (
    .clk(clk), .reset_n(rst0_n), .p_tick(p_tick0), .x(x0), .y(y0),
    .video_on(video_on0), .hsync(hsync0), .vsync(vsync0), .frame_tick(frame_tick0)
  );

  vga_sync_gen #(
    .CLK_DIV(D1), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_POL(POL1)
  ) dut1 (
    .clk(clk), .reset_n(rst1_n), .p_tick(p_tick1), .x(x1), .y(y1),
    .video_on(video_on1), .hsync(hsync1), .vsync(vsync1), .frame_tick(frame_tick1)
  );

  // Number of pixel ticks consumed by the counters after n edges.
  // p_tick first rises after the first edge.
  function automatic int ticks(input int n, input int d);
    if (n <= 1) return 0;
    if (d == 1) return n - 1;
    return n / d;
  endfunction

  // Expected {p_tick,x,y,video_on,hsync,vsync,frame_tick} after n edges
  // since release (n == 0 means in reset)
  function automatic logic [24:0] model(input int n, input int d, input bit pol);
    int t, tp, pos, xx, yy;
    logic p, von, hs, vs, ft;
    if (n == 0) return {1'b0, 10'd0, 10'd0, 1'b0, ~pol, ~pol, 1'b0};
    t   = ticks(n, d);
    tp  = ticks(n - 1, d);
    pos = t % (HT * VT);
    xx  = pos % HT;
    yy  = pos / HT;
    p   = (d == 1) ? 1'b1 : ((n % d) == d - 1);
    von = (xx < HD) && (yy < VD);
    hs  = (xx >= HD + HF && xx < HD + HF + HS) ? pol : ~pol;
    vs  = (yy >= VD + VF && yy < VD + VF + VS) ? pol : ~pol;
`ifdef VGA_FRAME_TICK_EN
    ft  = (t != tp) && (xx == 0) && (yy == VD + 1);
`else
    ft  = 1'b0;
`endif
    return {p, 10'(xx), 10'(yy), von, hs, vs, ft};
  endfunction

  task automatic test_reset();
    logic [24:0] e0, e1;
    rst0_n = 1'b0;
    rst1_n = 1'b0;
    n0 = 0;
    n1 = 0;
    repeat (2) @(posedge clk);
    #1;
    e0 = model(0, D0, POL0);
    e1 = model(0, D1, POL1);
    tests++;
    if (obs0 !== e0) begin
      fails++;
      $display("[TB] FAIL reset_dut0 got %h expected %h", obs0, e0);
    end
    tests++;
    if (obs1 !== e1) begin
      fails++;
      $display("[TB] FAIL reset_dut1 got %h expected %h", obs1, e1);
    end
  endtask

  // Runs four full frames and checks every clock against the model.
  // It also counts the per-frame totals seen on the pixel ticks.
  task automatic test_frames();
    logic [24:0] e;
    int vid = 0, hlow = 0, vlow = 0, fts = 0;
    @(negedge clk);
    rst0_n = 1'b1;
    n0 = 0;
    for (int i = 0; i < 4 * HT * VT * D0; i++) begin
      @(posedge clk);
      n0++;
      #1;
      e = model(n0, D0, POL0);
      tests++;
      if (obs0 !== e) begin
        fails++;
        $display("[TB] FAIL frames n=%0d got %h expected %h", n0, obs0, e);
      end
      if (p_tick0 && video_on0) vid++;
      if (p_tick0 && !hsync0)   hlow++;
      if (p_tick0 && !vsync0)   vlow++;
      if (frame_tick0)          fts++;
    end
    tests++;
    if (vid != 4 * HD * VD) begin
      fails++;
      $display("[TB] FAIL video_pixels got %0d expected %0d", vid, 4 * HD * VD);
    end
    tests++;
    if (hlow != 4 * VT * HS) begin
      fails++;
      $display("[TB] FAIL hsync_ticks got %0d expected %0d", hlow, 4 * VT * HS);
    end
    tests++;
    if (vlow != 4 * HT * VS) begin
      fails++;
      $display("[TB] FAIL vsync_ticks got %0d expected %0d", vlow, 4 * HT * VS);
    end
    tests++;
`ifdef VGA_FRAME_TICK_EN
    if (fts != 4) begin
      fails++;
      $display("[TB] FAIL frame_tick_count got %0d expected 4", fts);
    end
`else
    if (fts != 0) begin
      fails++;
      $display("[TB] FAIL frame_tick_count got %0d expected 0", fts);
    end
`endif
  endtask

  // The first full-frame wrap should land on (0,0), visible, with vsync idle
  task automatic test_wrap();
    rst0_n = 1'b0;
    @(negedge clk);
    rst0_n = 1'b1;
    n0 = 0;
    repeat (HT * VT * D0) begin
      @(posedge clk);
      n0++;
    end
    #1;
    tests++;
    if ({x0, y0, video_on0, vsync0} !== {10'd0, 10'd0, 1'b1, ~POL0}) begin
      fails++;
      $display("[TB] FAIL wrap got x=%0d y=%0d von=%b vs=%b expected 0 0 1 %b",
               x0, y0, video_on0, vsync0, ~POL0);
    end
  endtask

  // Asserts reset at a random point of the frame. The outputs must clear
  // before any edge, and the raster must restart from (0,0).
  task automatic test_mid_reset();
    logic [24:0] e;
    int run, after;
    for (int k = 0; k < 3; k++) begin
      run   = $urandom_range(100, 1500);
      after = $urandom_range(50, 300);
      rst0_n = 1'b0;
      @(negedge clk);
      rst0_n = 1'b1;
      n0 = 0;
      repeat (run) begin
        @(posedge clk);
        n0++;
        #1;
        e = model(n0, D0, POL0);
        tests++;
        if (obs0 !== e) begin
          fails++;
          $display("[TB] FAIL mid_run n=%0d got %h expected %h", n0, obs0, e);
        end
      end
      #2;
      rst0_n = 1'b0;
      #1;
      n0 = 0;
      e = model(0, D0, POL0);
      tests++;
      if (obs0 !== e) begin
        fails++;
        $display("[TB] FAIL async_reset got %h expected %h", obs0, e);
      end
      @(negedge clk);
      rst0_n = 1'b1;
      repeat (after) begin
        @(posedge clk);
        n0++;
        #1;
        e = model(n0, D0, POL0);
        tests++;
        if (obs0 !== e) begin
          fails++;
          $display("[TB] FAIL restart n=%0d got %h expected %h", n0, obs0, e);
        end
      end
    end
  endtask

  task automatic test_clk_div1();
    logic [24:0] e;
    int run;
    run = $urandom_range(3 * HT * VT, 4 * HT * VT);
    @(negedge clk);
    rst1_n = 1'b1;
    n1 = 0;
    repeat (run) begin
      @(posedge clk);
      n1++;
      #1;
      e = model(n1, D1, POL1);
      tests++;
      if (obs1 !== e) begin
        fails++;
        $display("[TB] FAIL div1 n=%0d got %h expected %h", n1, obs1, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_frames();
    test_wrap();
    test_mid_reset();
    test_clk_div1();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
